// File: rtl/mega99_wb_pkg.sv
// Shared Wishbone widths, idle read value and arbiter state encoding for the mainboard bus.
package mega99_wb_pkg;
    localparam int ADR_W = 24;
    localparam int DAT_W = 8;
    localparam logic [DAT_W-1:0] IDLE_DAT = 8'hFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_G0    = 2'd1;
    localparam logic [1:0] ST_G1    = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        G0    = ST_G0,
        G1    = ST_G1,
        ABORT = ST_ABORT
    } arb_state_e;
endpackage

// File: rtl/wb_timeout_counter.sv
// Stall watchdog for a Wishbone strobe: counts unanswered strobe cycles, saturating at the limit.
// limit_hit is registered-count based; a limit of 0 disables it entirely.
module wb_timeout_counter #(
    parameter int unsigned timeout_cycles = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic limit_hit
);
    localparam int CNT_W = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(timeout_cycles);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_hit = (timeout_cycles != 0) && (cnt_q == LIMIT);
endmodule

// File: rtl/mainboard_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter for the mainboard slave port; grant one edge after cyc.
// Slave ack/data pass through combinationally; the bus stays locked for the owner's whole cyc.
module mainboard_wb_arbiter
    import mega99_wb_pkg::*;
#(
    parameter int unsigned timeout_cycles = 255,
    parameter logic        m0_first       = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:ADR_W-1] m0_adr_i,
    input  logic [0:DAT_W-1] m0_dat_i,
    output logic [0:DAT_W-1] m0_dat_o,
    input  logic             m0_we_i,
    input  logic [0:0]       m0_sel_i,
    input  logic             m0_stb_i,
    input  logic             m0_cyc_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    input  logic [0:ADR_W-1] m1_adr_i,
    input  logic [0:DAT_W-1] m1_dat_i,
    output logic [0:DAT_W-1] m1_dat_o,
    input  logic             m1_we_i,
    input  logic [0:0]       m1_sel_i,
    input  logic             m1_stb_i,
    input  logic             m1_cyc_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [0:ADR_W-1] s_adr_o,
    output logic [0:DAT_W-1] s_dat_o,
    output logic             s_we_o,
    output logic [0:0]       s_sel_o,
    output logic             s_stb_o,
    output logic             s_cyc_o,
    input  logic [0:DAT_W-1] s_dat_i,
    input  logic             s_ack_i,
    output logic [0:1]       grant
);
    arb_state_e state_q, state_d;
    // last_q is written when a grant is made, so outside IDLE it also names the current owner.
    logic last_q, last_d;

    logic             own_cyc, own_stb, own_we;
    logic [0:0]       own_sel;
    logic [0:ADR_W-1] own_adr;
    logic [0:DAT_W-1] own_wdat, own_rdat;
    logic             granted, abort, ack, err, limit_hit;

    assign own_cyc  = last_q ? m1_cyc_i : m0_cyc_i;
    assign own_stb  = last_q ? m1_stb_i : m0_stb_i;
    assign own_we   = last_q ? m1_we_i  : m0_we_i;
    assign own_sel  = last_q ? m1_sel_i : m0_sel_i;
    assign own_adr  = last_q ? m1_adr_i : m0_adr_i;
    assign own_wdat = last_q ? m1_dat_i : m0_dat_i;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        granted = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    last_d  = ~last_q;
                    state_d = last_q ? G0 : G1;
                end else if (m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = G0;
                end else if (m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = G1;
                end
            end
            G0, G1: begin
                granted = 1'b1;
                // A slave ack landing on the limit cycle wins over the timeout.
                abort = limit_hit && !s_ack_i && own_cyc;
                if (!own_cyc) begin
                    state_d = IDLE;
                end else if (abort) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        ack      = 1'b0;
        err      = 1'b0;
        own_rdat = IDLE_DAT;
        if (granted) begin
            s_adr_o  = own_adr;
            s_dat_o  = own_wdat;
            s_we_o   = own_we;
            s_sel_o  = own_sel;
            s_stb_o  = own_stb && !abort;
            s_cyc_o  = own_cyc;
            ack      = s_ack_i && !reset;
            err      = abort && !reset;
            own_rdat = abort ? IDLE_DAT : s_dat_i;
        end
    end

    assign m0_ack_o = ack && !last_q;
    assign m1_ack_o = ack && last_q;
    assign m0_err_o = err && !last_q;
    assign m1_err_o = err && last_q;
    assign m0_dat_o = last_q ? IDLE_DAT : own_rdat;
    assign m1_dat_o = last_q ? own_rdat : IDLE_DAT;
    // The aborted master keeps its grant bit until it releases cyc, so the bus still reads as taken.
    assign grant    = {(state_q != IDLE) && !last_q, (state_q != IDLE) && last_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= m0_first;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    wb_timeout_counter #(.timeout_cycles(timeout_cycles)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (!granted || s_ack_i || !s_stb_o),
        .count_en (s_stb_o && !s_ack_i),
        .limit_hit(limit_hit)
    );
endmodule

// File: tb/tb_mainboard_wb_arbiter.sv
// Bench for mainboard_wb_arbiter: vector table, corner-case sequences and a random run against a model.
module tb_mainboard_wb_arbiter;
    localparam int T = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [0:23] m0_adr_i, m1_adr_i;
    logic [0:7]  m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
    logic        m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o, m0_err_o;
    logic        m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o, m1_err_o;
    logic [0:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic [0:23] s_adr_o;
    logic [0:7]  s_dat_o, s_dat_i;
    logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;
    logic [0:1]  grant;

    logic [0:7]  nt_m0_dat_o, nt_m1_dat_o, nt_s_dat_o;
    logic        nt_m0_ack_o, nt_m0_err_o, nt_m1_ack_o, nt_m1_err_o;
    logic [0:23] nt_s_adr_o;
    logic        nt_s_we_o, nt_s_stb_o, nt_s_cyc_o;
    logic [0:0]  nt_s_sel_o;
    logic [0:1]  nt_grant;

    mainboard_wb_arbiter #(.timeout_cycles(T), .m0_first(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_stb_o(s_stb_o),
        .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant(grant)
    );

    mainboard_wb_arbiter #(.timeout_cycles(0), .m0_first(1'b1)) dut_nt (
        .clk(clk), .reset(reset),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(nt_m0_dat_o), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(nt_m0_ack_o), .m0_err_o(nt_m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(nt_m1_dat_o), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(nt_m1_ack_o), .m1_err_o(nt_m1_err_o),
        .s_adr_o(nt_s_adr_o), .s_dat_o(nt_s_dat_o), .s_we_o(nt_s_we_o), .s_sel_o(nt_s_sel_o), .s_stb_o(nt_s_stb_o),
        .s_cyc_o(nt_s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant(nt_grant)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_sel_i = '0; m0_stb_i = 1'b0; m0_cyc_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_sel_i = '0; m1_stb_i = 1'b0; m1_cyc_i = 1'b0;
        s_ack_i = 1'b0; s_dat_i = '0;
    endtask

    // ---------------- reference model: owner index, abort flag, stall count ----------------
    int   mdl_owner, mdl_last, mdl_stall;
    bit   mdl_abort, mdl_hit;
    logic [0:1]  e_grant;
    logic        e_scyc, e_sstb, e_swe, e_ack0, e_ack1, e_err0, e_err1;
    logic [0:0]  e_ssel;
    logic [0:23] e_sadr;
    logic [0:7]  e_sdat, e_dat0, e_dat1;

    function automatic logic cyc_of(input int m);
        return (m == 0) ? m0_cyc_i : m1_cyc_i;
    endfunction

    task automatic model_reset();
        mdl_owner = -1; mdl_abort = 0; mdl_stall = 0;
        mdl_last  = 1;   // m0_first = 1: master 0 wins the first tie
    endtask

    task automatic model_eval();
        logic o_cyc, o_stb;
        e_grant = 2'b00; e_scyc = 0; e_sstb = 0; e_swe = 0; e_ssel = '0; e_sadr = '0; e_sdat = '0;
        e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0; e_dat0 = 8'hFF; e_dat1 = 8'hFF;
        mdl_hit = 0;
        if (mdl_owner >= 0) begin
            e_grant = (mdl_owner == 0) ? 2'b10 : 2'b01;
            if (!mdl_abort) begin
                o_cyc   = cyc_of(mdl_owner);
                o_stb   = (mdl_owner == 0) ? m0_stb_i : m1_stb_i;
                mdl_hit = (T != 0) && (mdl_stall == T) && !s_ack_i && o_cyc;
                e_scyc  = o_cyc;
                e_sstb  = o_stb && !mdl_hit;
                e_swe   = (mdl_owner == 0) ? m0_we_i  : m1_we_i;
                e_ssel  = (mdl_owner == 0) ? m0_sel_i : m1_sel_i;
                e_sadr  = (mdl_owner == 0) ? m0_adr_i : m1_adr_i;
                e_sdat  = (mdl_owner == 0) ? m0_dat_i : m1_dat_i;
                if (mdl_owner == 0) begin
                    e_ack0 = s_ack_i; e_err0 = mdl_hit; e_dat0 = mdl_hit ? 8'hFF : s_dat_i;
                end else begin
                    e_ack1 = s_ack_i; e_err1 = mdl_hit; e_dat1 = mdl_hit ? 8'hFF : s_dat_i;
                end
            end
        end
    endtask

    task automatic model_advance();
        if (mdl_owner < 0) begin
            if (m0_cyc_i && m1_cyc_i) mdl_owner = 1 - mdl_last;
            else if (m0_cyc_i)        mdl_owner = 0;
            else if (m1_cyc_i)        mdl_owner = 1;
            mdl_stall = 0;
        end else if (mdl_abort) begin
            mdl_stall = 0;
            if (!cyc_of(mdl_owner)) begin
                mdl_last = mdl_owner; mdl_owner = -1; mdl_abort = 0;
            end
        end else begin
            if (e_sstb && !s_ack_i) mdl_stall = (mdl_stall < T) ? mdl_stall + 1 : T;
            else                    mdl_stall = 0;
            if (!cyc_of(mdl_owner)) begin
                mdl_last = mdl_owner; mdl_owner = -1; mdl_stall = 0;
            end else if (mdl_hit) begin
                mdl_abort = 1; mdl_stall = 0;
            end
        end
    endtask

    task automatic compare_model();
        chk("rnd_grant", 32'(grant), 32'(e_grant));
        chk("rnd_s_cyc", 32'(s_cyc_o), 32'(e_scyc));
        chk("rnd_s_stb", 32'(s_stb_o), 32'(e_sstb));
        chk("rnd_s_we", 32'(s_we_o), 32'(e_swe));
        chk("rnd_s_sel", 32'(s_sel_o), 32'(e_ssel));
        chk("rnd_s_adr", 32'(s_adr_o), 32'(e_sadr));
        chk("rnd_s_dat", 32'(s_dat_o), 32'(e_sdat));
        chk("rnd_m0_ack", 32'(m0_ack_o), 32'(e_ack0));
        chk("rnd_m1_ack", 32'(m1_ack_o), 32'(e_ack1));
        chk("rnd_m0_err", 32'(m0_err_o), 32'(e_err0));
        chk("rnd_m1_err", 32'(m1_err_o), 32'(e_err1));
        chk("rnd_m0_dat", 32'(m0_dat_o), 32'(e_dat0));
        chk("rnd_m1_dat", 32'(m1_dat_o), 32'(e_dat1));
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct packed {
        logic       rst, c0, s0, c1, s1, ack;
        logic [7:0] sdat;
        logic [1:0] g;
        logic       sstb, a0, a1;
        logic [7:0] d0, d1;
    } vec_t;

    function automatic vec_t v(logic rst, logic c0, logic s0, logic c1, logic s1, logic ack, logic [7:0] sdat,
                               logic [1:0] g, logic sstb, logic a0, logic a1, logic [7:0] d0, logic [7:0] d1);
        return '{rst, c0, s0, c1, s1, ack, sdat, g, sstb, a0, a1, d0, d1};
    endfunction

    vec_t vec[$];
    int   pulses, first_err, nt_errs;

    initial begin
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        model_reset();

        // Lone m0 read, then simultaneous requests with round-robin handover.
        vec.push_back(v(1,0,0,0,0,0,8'h00, 2'b00,0,0,0,8'hFF,8'hFF));
        vec.push_back(v(0,1,1,0,0,0,8'h00, 2'b00,0,0,0,8'hFF,8'hFF));
        vec.push_back(v(0,1,1,0,0,0,8'h11, 2'b10,1,0,0,8'h11,8'hFF));
        vec.push_back(v(0,1,1,0,0,0,8'h22, 2'b10,1,0,0,8'h22,8'hFF));
        vec.push_back(v(0,1,1,0,0,0,8'h33, 2'b10,1,0,0,8'h33,8'hFF));
        vec.push_back(v(0,1,1,0,0,1,8'hA5, 2'b10,1,1,0,8'hA5,8'hFF));
        vec.push_back(v(0,0,0,0,0,0,8'h00, 2'b10,0,0,0,8'h00,8'hFF));
        vec.push_back(v(0,0,0,0,0,0,8'h00, 2'b00,0,0,0,8'hFF,8'hFF));
        vec.push_back(v(1,0,0,0,0,0,8'h00, 2'b00,0,0,0,8'hFF,8'hFF));
        vec.push_back(v(0,1,1,1,1,0,8'h00, 2'b00,0,0,0,8'hFF,8'hFF));
        vec.push_back(v(0,1,1,1,1,1,8'h3C, 2'b10,1,1,0,8'h3C,8'hFF));
        vec.push_back(v(0,0,0,1,1,0,8'h00, 2'b10,0,0,0,8'h00,8'hFF));
        vec.push_back(v(0,0,0,1,1,0,8'h00, 2'b00,0,0,0,8'hFF,8'hFF));
        vec.push_back(v(0,0,0,1,1,1,8'h5A, 2'b01,1,0,1,8'hFF,8'h5A));
        vec.push_back(v(0,0,0,0,0,0,8'h00, 2'b01,0,0,0,8'hFF,8'h00));
        vec.push_back(v(0,0,0,0,0,0,8'h00, 2'b00,0,0,0,8'hFF,8'hFF));
        vec.push_back(v(0,1,1,1,1,0,8'h00, 2'b00,0,0,0,8'hFF,8'hFF));
        vec.push_back(v(0,1,1,1,1,1,8'h66, 2'b10,1,1,0,8'h66,8'hFF));
        vec.push_back(v(0,0,0,1,1,0,8'h00, 2'b10,0,0,0,8'h00,8'hFF));
        vec.push_back(v(0,0,0,1,1,0,8'h00, 2'b00,0,0,0,8'hFF,8'hFF));
        vec.push_back(v(0,0,0,1,1,1,8'h77, 2'b01,1,0,1,8'hFF,8'h77));
        vec.push_back(v(0,0,0,0,0,0,8'h00, 2'b01,0,0,0,8'hFF,8'h00));
        vec.push_back(v(0,0,0,0,0,0,8'h00, 2'b00,0,0,0,8'hFF,8'hFF));

        m0_adr_i = 24'h010000;
        m1_adr_i = 24'h003F00;
        foreach (vec[i]) begin
            reset = vec[i].rst;
            m0_cyc_i = vec[i].c0; m0_stb_i = vec[i].s0;
            m1_cyc_i = vec[i].c1; m1_stb_i = vec[i].s1;
            s_ack_i = vec[i].ack; s_dat_i = vec[i].sdat;
            #2;
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vec[i].g));
            chk($sformatf("vec%0d_s_stb", i), 32'(s_stb_o), 32'(vec[i].sstb));
            chk($sformatf("vec%0d_m0_ack", i), 32'(m0_ack_o), 32'(vec[i].a0));
            chk($sformatf("vec%0d_m1_ack", i), 32'(m1_ack_o), 32'(vec[i].a1));
            chk($sformatf("vec%0d_m0_dat", i), 32'(m0_dat_o), 32'(vec[i].d0));
            chk($sformatf("vec%0d_m1_dat", i), 32'(m1_dat_o), 32'(vec[i].d1));
            chk($sformatf("vec%0d_errs", i), 32'({m0_err_o, m1_err_o}), 32'd0);
            step();
        end
        reset = 1'b0;

        // m1 locks the bus for four write strobes while m0 waits.
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 24'h003F00; m1_dat_i = 8'hD0;
        #2 chk("lock_idle_grant", 32'(grant), 32'd0);
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h010000;
        for (int i = 0; i < 4; i++) begin
            m1_adr_i = 24'h003F00 + 24'(i); m1_dat_i = 8'hD0 + 8'(i); s_ack_i = 1;
            #2;
            chk("lock_grant", 32'(grant), 32'(2'b01));
            chk("lock_s_adr", 32'(s_adr_o), 32'h003F00 + 32'(i));
            chk("lock_s_dat", 32'(s_dat_o), 32'hD0 + 32'(i));
            chk("lock_s_we_stb", 32'({s_we_o, s_stb_o}), 32'd3);
            chk("lock_acks", 32'({m0_ack_o, m1_ack_o}), 32'(2'b01));
            step();
        end
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; s_ack_i = 0;
        #2 chk("lock_release_grant", 32'(grant), 32'(2'b01));
        step();
        #2 chk("lock_gap_grant", 32'(grant), 32'd0);
        step();
        #2 chk("lock_m0_grant", 32'(grant), 32'(2'b10));
        chk("lock_m0_adr", 32'(s_adr_o), 32'h010000);
        idle_inputs();
        step();
        step();

        // Stalled slave: single err pulse, late ack ignored while aborting.
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h010000;
        pulses = 0; first_err = -1;
        for (int c = 0; c <= 20; c++) begin
            s_ack_i = (c == 11); s_dat_i = (c == 11) ? 8'h77 : 8'h00;
            #2;
            if (m0_err_o) begin
                pulses++;
                if (first_err < 0) first_err = c;
            end
            if (c == 9) begin
                chk("to_err", 32'(m0_err_o), 32'd1);
                chk("to_err_dat", 32'(m0_dat_o), 32'hFF);
                chk("to_err_stb", 32'(s_stb_o), 32'd0);
            end
            if (c == 11) begin
                chk("to_late_ack", 32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 32'd0);
                chk("to_late_dat", 32'(m0_dat_o), 32'hFF);
                chk("to_abort_cyc", 32'({s_cyc_o, s_stb_o}), 32'd0);
            end
            step();
        end
        chk("to_err_pulses", 32'(pulses), 32'd1);
        chk("to_err_cycle", 32'(first_err), 32'd9);
        idle_inputs();
        step();
        #2 chk("to_back_idle", 32'(grant), 32'd0);
        step();

        // Ack on the limit cycle wins over the timeout.
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int c = 0; c <= 10; c++) begin
            s_ack_i = (c == 9); s_dat_i = (c == 9) ? 8'h42 : 8'h00;
            #2;
            if (c == 9) begin
                chk("lim_ack", 32'({m0_ack_o, m0_err_o}), 32'(2'b10));
                chk("lim_dat", 32'(m0_dat_o), 32'h42);
                chk("lim_stb", 32'(s_stb_o), 32'd1);
            end
            if (c == 10) begin
                chk("lim_after_err", 32'(m0_err_o), 32'd0);
                chk("lim_after_grant", 32'(grant), 32'(2'b10));
            end
            step();
        end
        idle_inputs();
        step();

        // Timeout disabled: a long stall never errors.
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        nt_errs = 0;
        for (int c = 0; c < 1000; c++) begin
            #2;
            if (nt_m0_err_o) nt_errs++;
            step();
        end
        chk("nt_no_err", 32'(nt_errs), 32'd0);
        chk("nt_grant", 32'(nt_grant), 32'(2'b10));
        chk("nt_stb", 32'(nt_s_stb_o), 32'd1);
        idle_inputs();
        step();

        // Reset during an m1 transfer, then a normal m0 transfer.
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 24'h003F10;
        step();
        #2 chk("rst_g1_grant", 32'(grant), 32'(2'b01));
        reset = 1; s_ack_i = 1;
        #1 chk("rst_cycle_ackerr", 32'({m1_ack_o, m1_err_o}), 32'd0);
        step();
        reset = 0; s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h012345;
        #2;
        chk("rst_after_grant", 32'(grant), 32'd0);
        chk("rst_after_cyc", 32'(s_cyc_o), 32'd0);
        chk("rst_after_ack", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'd0);
        step();
        s_ack_i = 1; s_dat_i = 8'h9E;
        #2;
        chk("rst_m0_grant", 32'(grant), 32'(2'b10));
        chk("rst_m0_adr", 32'(s_adr_o), 32'h012345);
        chk("rst_m0_ack", 32'({m0_ack_o, m0_dat_o}), 32'h19E);
        step();

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (m0_cyc_i) begin
                if ($urandom_range(11) == 0) m0_cyc_i = 0;
            end else if ($urandom_range(3) == 0) m0_cyc_i = 1;
            m0_stb_i = m0_cyc_i && ($urandom_range(3) != 0);
            m0_we_i = 1'($urandom_range(1)); m0_sel_i = 1'($urandom_range(1));
            m0_adr_i = 24'($urandom); m0_dat_i = 8'($urandom);
            if (m1_cyc_i) begin
                if ($urandom_range(11) == 0) m1_cyc_i = 0;
            end else if ($urandom_range(3) == 0) m1_cyc_i = 1;
            m1_stb_i = m1_cyc_i && ($urandom_range(3) != 0);
            m1_we_i = 1'($urandom_range(1)); m1_sel_i = 1'($urandom_range(1));
            m1_adr_i = 24'($urandom); m1_dat_i = 8'($urandom);
            s_ack_i = (n < 1500) ? ($urandom_range(4) == 0) : ($urandom_range(11) == 0);
            s_dat_i = 8'($urandom);
            #2;
            model_eval();
            compare_model();
            model_advance();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
